// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared types and constants for the TLB lookup arbiter and its per-side result buffers.
package tlb_lookup_arbiter_pkg;

  localparam int unsigned DEFAULT_PAGE_BITS = 12;

  localparam logic        true     = 1'b1;
  localparam logic        false    = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  typedef struct packed {
    logic cat;
    logic tlbr;
    logic tlbi;
    logic tlbm;
  } tlb_flags_t;

  localparam tlb_flags_t NO_FLAGS = '0;

endpackage

// File: rtl/tlb_lookup_arbiter_result_buffer.sv
// One-entry page-result buffer: holds the last translation for one MMU and answers hits
// combinationally so a stalled requester keeps seeing a stable result.
module tlb_result_buffer
  import tlb_lookup_arbiter_pkg::*;
#(
  parameter int unsigned  PAGE_BITS = DEFAULT_PAGE_BITS,
  localparam int unsigned TAG_W     = 32 - PAGE_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      vaddr,
  input  logic             refs,
  input  logic             wr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_refs,
  input  logic [TAG_W-1:0] wr_pfn,
  input  tlb_flags_t       wr_flags,
  input  logic             clr,
  output logic             hit,
  output logic [31:0]      paddr,
  output tlb_flags_t       flags
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic             refs_q;
  logic [TAG_W-1:0] pfn_q;
  tlb_flags_t       flags_q;

  // Entry storage; a clear always wins over a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= false;
      tag_q   <= '0;
      refs_q  <= false;
      pfn_q   <= '0;
      flags_q <= NO_FLAGS;
    end else begin
      if (clr) begin
        valid_q <= false;
      end else if (wr) begin
        valid_q <= true;
      end
      if (wr) begin
        tag_q   <= wr_tag;
        refs_q  <= wr_refs;
        pfn_q   <= wr_pfn;
        flags_q <= wr_flags;
      end
    end
  end

  // Exact tag/store-flag compare; every result field reads zero without a hit.
  always_comb begin
    hit   = en && valid_q && (tag_q == vaddr[31:PAGE_BITS]) && (refs_q == refs);
    paddr = ZeroWord;
    flags = NO_FLAGS;
    if (hit) begin
      paddr = {pfn_q, vaddr[PAGE_BITS-1:0]};
      flags = flags_q;
    end
  end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Shares one TLB lookup engine between the inst- and data-side MMUs: per-side result
// buffers serve hits, misses are sequenced round-robin onto the engine.
module tlb_lookup_arbiter
  import tlb_lookup_arbiter_pkg::*;
#(
  parameter int unsigned  PAGE_BITS = DEFAULT_PAGE_BITS,
  localparam int unsigned PFN_W     = 32 - PAGE_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [31:0]      i_vaddr,
  input  logic             i_refs,
  output logic             i_rdy,
  output logic [31:0]      i_paddr,
  output logic             i_cat,
  output logic             i_tlbr,
  output logic             i_tlbi,
  output logic             i_tlbm,
  input  logic             d_en,
  input  logic [31:0]      d_vaddr,
  input  logic             d_refs,
  output logic             d_rdy,
  output logic [31:0]      d_paddr,
  output logic             d_cat,
  output logic             d_tlbr,
  output logic             d_tlbi,
  output logic             d_tlbm,
  output logic             lk_start,
  output logic [31:0]      lk_vaddr,
  output logic             lk_refs,
  input  logic             lk_done,
  input  logic [PFN_W-1:0] lk_pfn,
  input  logic             lk_cat,
  input  logic             lk_tlbr,
  input  logic             lk_tlbi,
  input  logic             lk_tlbm,
  input  logic             flush
);

  state_e     state_q, state_d;
  grant_e     owner_q, last_grant_q, grant_c;
  logic       poisoned_q;
  logic       launch_c, wr_i_c, wr_d_c;
  logic       i_hit, d_hit, i_pend, d_pend;
  tlb_flags_t lk_flags, i_flags, d_flags;

  assign lk_flags = '{cat: lk_cat, tlbr: lk_tlbr, tlbi: lk_tlbi, tlbm: lk_tlbm};
  assign i_pend   = i_en && !i_hit;
  assign d_pend   = d_en && !d_hit;

  tlb_result_buffer #(.PAGE_BITS(PAGE_BITS)) u_i_buf (
    .clk(clk), .rst(rst), .en(i_en), .vaddr(i_vaddr), .refs(i_refs),
    .wr(wr_i_c), .wr_tag(lk_vaddr[31:PAGE_BITS]), .wr_refs(lk_refs), .wr_pfn(lk_pfn),
    .wr_flags(lk_flags), .clr(flush), .hit(i_hit), .paddr(i_paddr), .flags(i_flags)
  );

  tlb_result_buffer #(.PAGE_BITS(PAGE_BITS)) u_d_buf (
    .clk(clk), .rst(rst), .en(d_en), .vaddr(d_vaddr), .refs(d_refs),
    .wr(wr_d_c), .wr_tag(lk_vaddr[31:PAGE_BITS]), .wr_refs(lk_refs), .wr_pfn(lk_pfn),
    .wr_flags(lk_flags), .clr(flush), .hit(d_hit), .paddr(d_paddr), .flags(d_flags)
  );

  assign i_rdy  = i_hit;
  assign i_cat  = i_flags.cat;
  assign i_tlbr = i_flags.tlbr;
  assign i_tlbi = i_flags.tlbi;
  assign i_tlbm = i_flags.tlbm;
  assign d_rdy  = d_hit;
  assign d_cat  = d_flags.cat;
  assign d_tlbr = d_flags.tlbr;
  assign d_tlbi = d_flags.tlbi;
  assign d_tlbm = d_flags.tlbm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_pend || d_pend) state_d = BUSY;
      BUSY:    if (lk_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and buffer-write decode; a flush seen in or before the done cycle drops the result.
  always_comb begin
    launch_c = false;
    grant_c  = GRANT_INST;
    wr_i_c   = false;
    wr_d_c   = false;
    case (state_q)
      IDLE: begin
        launch_c = i_pend || d_pend;
        if (d_pend && (!i_pend || (last_grant_q == GRANT_INST))) grant_c = GRANT_DATA;
      end
      BUSY: begin
        if (lk_done && !poisoned_q && !flush) begin
          wr_i_c = (owner_q == GRANT_INST);
          wr_d_c = (owner_q == GRANT_DATA);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_start     <= false;
      lk_vaddr     <= ZeroWord;
      lk_refs      <= false;
      owner_q      <= GRANT_INST;
      last_grant_q <= GRANT_INST;
      poisoned_q   <= false;
    end else begin
      lk_start <= launch_c;
      if (launch_c) begin
        lk_vaddr     <= (grant_c == GRANT_DATA) ? d_vaddr : i_vaddr;
        lk_refs      <= (grant_c == GRANT_DATA) ? d_refs : i_refs;
        owner_q      <= grant_c;
        last_grant_q <= grant_c;
        poisoned_q   <= false;
      end else if ((state_q == BUSY) && flush) begin
        poisoned_q <= true;
      end
    end
  end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed bench for tlb_lookup_arbiter: hand-driven lookup engine, hit table, and
// multi-cycle sequences for arbitration, flush and reset corners.
module tb_tlb_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_refs, d_en, d_refs;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_rdy, i_cat, i_tlbr, i_tlbi, i_tlbm;
  logic        d_rdy, d_cat, d_tlbr, d_tlbi, d_tlbm;
  logic [31:0] i_paddr, d_paddr;
  logic        lk_start, lk_refs, lk_done, lk_cat, lk_tlbr, lk_tlbi, lk_tlbm, flush;
  logic [31:0] lk_vaddr;
  logic [19:0] lk_pfn;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  tlb_lookup_arbiter #(.PAGE_BITS(12)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_vaddr(i_vaddr), .i_refs(i_refs), .i_rdy(i_rdy), .i_paddr(i_paddr),
    .i_cat(i_cat), .i_tlbr(i_tlbr), .i_tlbi(i_tlbi), .i_tlbm(i_tlbm),
    .d_en(d_en), .d_vaddr(d_vaddr), .d_refs(d_refs), .d_rdy(d_rdy), .d_paddr(d_paddr),
    .d_cat(d_cat), .d_tlbr(d_tlbr), .d_tlbi(d_tlbi), .d_tlbm(d_tlbm),
    .lk_start(lk_start), .lk_vaddr(lk_vaddr), .lk_refs(lk_refs), .lk_done(lk_done),
    .lk_pfn(lk_pfn), .lk_cat(lk_cat), .lk_tlbr(lk_tlbr), .lk_tlbi(lk_tlbi),
    .lk_tlbm(lk_tlbm), .flush(flush)
  );

  always #5 clk = ~clk;

  // lk_start is a full-cycle pulse, so counting on the falling edge is race-free.
  always @(negedge clk) if (lk_start === 1'b1) start_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        side_d;
    logic        en;
    logic [31:0] vaddr;
    logic        refs;
    logic        exp_rdy;
    logic [31:0] exp_paddr;
    logic        exp_cat;
    logic        exp_tlbm;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next lk_start; report cycles waited and the registered request.
  task automatic wait_start(input string nm, output int n, output logic [31:0] va,
                            output logic r);
    n  = 0;
    va = 32'h0;
    r  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (lk_start === 1'b1) begin
        n  = k;
        va = lk_vaddr;
        r  = lk_refs;
        break;
      end
    end
    if (n == 0) chk({nm, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  // Engine model: answer lat cycles after the start cycle, done held for one cycle.
  task automatic finish(input int lat, input logic [19:0] pfn, input logic cat,
                        input logic tr, input logic ti, input logic tm);
    repeat (lat) cyc();
    lk_done = 1'b1; lk_pfn = pfn; lk_cat = cat; lk_tlbr = tr; lk_tlbi = ti; lk_tlbm = tm;
    cyc();
    lk_done = 1'b0; lk_pfn = 20'h0; lk_cat = 1'b0; lk_tlbr = 1'b0; lk_tlbi = 1'b0;
    lk_tlbm = 1'b0;
  endtask

  initial begin
    int          n, base;
    logic [31:0] va;
    logic        r;

    vecs[0] = '{"same_page_hi",  1'b1, 1'b1, 32'h0040_1FFC, 1'b0, 1'b1, 32'h1F00_AFFC, 1'b1, 1'b0};
    vecs[1] = '{"same_page_lo",  1'b1, 1'b1, 32'h0040_1000, 1'b0, 1'b1, 32'h1F00_A000, 1'b1, 1'b0};
    vecs[2] = '{"en_low",        1'b1, 1'b0, 32'h0040_1234, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{"refs_mismatch", 1'b1, 1'b1, 32'h0040_1234, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{"prev_page",     1'b1, 1'b1, 32'h0040_0FFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{"next_page",     1'b1, 1'b1, 32'h0040_2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{"tag_msb",       1'b1, 1'b1, 32'h8040_1234, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[7] = '{"inst_separate", 1'b0, 1'b1, 32'h0040_1234, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0;
    i_en = 1'b0; i_vaddr = 32'h0; i_refs = 1'b0;
    d_en = 1'b0; d_vaddr = 32'h0; d_refs = 1'b0;
    lk_done = 1'b0; lk_pfn = 20'h0; lk_cat = 1'b0; lk_tlbr = 1'b0; lk_tlbi = 1'b0;
    lk_tlbm = 1'b0;
    cyc(); cyc();
    chk("reset_lk_start", 32'(lk_start), 32'd0);
    chk("reset_lk_vaddr", lk_vaddr, 32'h0);
    chk("reset_lk_refs", 32'(lk_refs), 32'd0);
    chk("reset_d_rdy", 32'(d_rdy), 32'd0);
    chk("reset_i_rdy", 32'(i_rdy), 32'd0);
    rst = 1'b0;
    cyc();

    // Single data miss, engine latency 3.
    d_en = 1'b1; d_vaddr = 32'h0040_1234; d_refs = 1'b0;
    #1 chk("miss_rdy_low", 32'(d_rdy), 32'd0);
    wait_start("miss", n, va, r);
    chk("miss_start_latency", 32'(n), 32'd1);
    chk("miss_lk_vaddr", va, 32'h0040_1234);
    repeat (3) cyc();
    lk_done = 1'b1; lk_pfn = 20'h1F00A; lk_cat = 1'b1;
    #1 chk("miss_rdy_in_done_cycle", 32'(d_rdy), 32'd0);
    cyc();
    lk_done = 1'b0; lk_pfn = 20'h0; lk_cat = 1'b0;
    chk("miss_rdy", 32'(d_rdy), 32'd1);
    chk("miss_paddr", d_paddr, 32'h1F00_A234);
    chk("miss_cat", 32'(d_cat), 32'd1);
    base = start_cnt;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_rdy", 32'(d_rdy), 32'd1);
    end
    chk("hold_no_restart", 32'(start_cnt), 32'(base));

    // Hit table; each vector lives inside one cycle so misses never reach an edge.
    for (int k = 0; k < 8; k++) begin
      cyc();
      d_en = 1'b0; i_en = 1'b0;
      if (vecs[k].side_d) begin
        d_en = vecs[k].en; d_vaddr = vecs[k].vaddr; d_refs = vecs[k].refs;
        #2;
        chk({vecs[k].name, "_rdy"}, 32'(d_rdy), 32'(vecs[k].exp_rdy));
        chk({vecs[k].name, "_paddr"}, d_paddr, vecs[k].exp_paddr);
        chk({vecs[k].name, "_cat"}, 32'(d_cat), 32'(vecs[k].exp_cat));
        chk({vecs[k].name, "_tlbm"}, 32'(d_tlbm), 32'(vecs[k].exp_tlbm));
      end else begin
        i_en = vecs[k].en; i_vaddr = vecs[k].vaddr; i_refs = vecs[k].refs;
        #2;
        chk({vecs[k].name, "_rdy"}, 32'(i_rdy), 32'(vecs[k].exp_rdy));
        chk({vecs[k].name, "_paddr"}, i_paddr, vecs[k].exp_paddr);
        chk({vecs[k].name, "_cat"}, 32'(i_cat), 32'(vecs[k].exp_cat));
        chk({vecs[k].name, "_tlbm"}, 32'(i_tlbm), 32'(vecs[k].exp_tlbm));
      end
      d_en = 1'b0; i_en = 1'b0; d_refs = 1'b0;
    end
    cyc();
    chk("table_no_lookup", 32'(start_cnt), 32'(base));

    // Store to a page buffered as a load.
    d_en = 1'b1; d_vaddr = 32'h0040_1234; d_refs = 1'b1;
    #1 chk("store_miss", 32'(d_rdy), 32'd0);
    wait_start("store", n, va, r);
    chk("store_lk_refs", 32'(r), 32'd1);
    finish(2, 20'h1F00A, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("store_rdy", 32'(d_rdy), 32'd1);
    chk("store_tlbm", 32'(d_tlbm), 32'd1);
    chk("store_paddr", d_paddr, 32'h1F00_A234);
    d_en = 1'b0; d_refs = 1'b0;
    cyc();

    // Tie after a data grant: inst goes first.
    i_en = 1'b1; i_vaddr = 32'h0040_0100;
    d_en = 1'b1; d_vaddr = 32'h0040_3000;
    wait_start("tie_a", n, va, r);
    chk("tie_first_inst", va, 32'h0040_0100);
    finish(1, 20'h0B000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_start("tie_b", n, va, r);
    chk("tie_second_data", va, 32'h0040_3000);
    chk("tie_gap", 32'(n), 32'd1);
    finish(1, 20'h0C000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tie_i_rdy", 32'(i_rdy), 32'd1);
    chk("tie_i_tlbi", 32'(i_tlbi), 32'd1);
    chk("tie_i_paddr", i_paddr, 32'h0B00_0100);
    chk("tie_d_tlbr", 32'(d_tlbr), 32'd1);
    chk("tie_d_paddr", d_paddr, 32'h0C00_0000);
    i_en = 1'b0;

    // Flush in the same cycle as a hit.
    d_vaddr = 32'h0040_3010; flush = 1'b1;
    #1 chk("flush_hit_same_cycle", 32'(d_rdy), 32'd1);
    cyc();
    flush = 1'b0;
    #1 chk("flush_hit_next_cycle", 32'(d_rdy), 32'd0);
    d_en = 1'b0;
    cyc();

    // Flush while BUSY: first result dropped, request looked up again.
    base = start_cnt;
    d_en = 1'b1; d_vaddr = 32'h0050_0000;
    wait_start("fbusy_a", n, va, r);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    finish(1, 20'h22222, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_busy_discard", 32'(d_rdy), 32'd0);
    wait_start("fbusy_b", n, va, r);
    chk("flush_busy_relookup", va, 32'h0050_0000);
    finish(1, 20'h33333, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_busy_rdy", 32'(d_rdy), 32'd1);
    chk("flush_busy_paddr", d_paddr, 32'h3333_3000);
    chk("flush_busy_starts", 32'(start_cnt - base), 32'd2);

    // Flush coinciding with lk_done.
    d_vaddr = 32'h0050_1000;
    wait_start("fdone_a", n, va, r);
    cyc();
    lk_done = 1'b1; lk_pfn = 20'h44444; flush = 1'b1;
    cyc();
    lk_done = 1'b0; lk_pfn = 20'h0; flush = 1'b0;
    chk("flush_done_discard", 32'(d_rdy), 32'd0);
    wait_start("fdone_b", n, va, r);
    finish(2, 20'h55555, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_done_paddr", d_paddr, 32'h5555_5000);
    d_en = 1'b0;

    // Async reset in the middle of a lookup.
    i_en = 1'b1; i_vaddr = 32'h0090_0000;
    wait_start("rst_fill", n, va, r);
    finish(1, 20'h09999, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_i_rdy", 32'(i_rdy), 32'd1);
    d_en = 1'b1; d_vaddr = 32'h0060_0000;
    wait_start("rst_a", n, va, r);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_lk_start", 32'(lk_start), 32'd0);
    chk("rst_async_lk_vaddr", lk_vaddr, 32'h0);
    chk("rst_async_i_rdy", 32'(i_rdy), 32'd0);
    chk("rst_async_i_paddr", i_paddr, 32'h0);
    i_en = 1'b0; d_en = 1'b0;
    cyc();
    rst = 1'b0;
    base = start_cnt;
    lk_done = 1'b1; lk_pfn = 20'h77777;
    cyc();
    lk_done = 1'b0; lk_pfn = 20'h0;
    cyc();
    chk("stray_done_no_start", 32'(start_cnt), 32'(base));
    d_en = 1'b1;
    #1 chk("stray_done_no_write", 32'(d_rdy), 32'd0);
    wait_start("rst_b", n, va, r);
    chk("rst_fresh_latency", 32'(n), 32'd1);
    finish(1, 20'h06666, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_fresh_paddr", d_paddr, 32'h0666_6000);
    d_en = 1'b0;

    // Clean reset, then four back-to-back miss pairs: data, inst, data, inst, ...
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    base = start_cnt;
    for (int k = 0; k < 4; k++) begin
      i_en = 1'b1; i_vaddr = 32'h0070_0000 + (32'(k) << 12) + 32'h10;
      d_en = 1'b1; d_vaddr = 32'h0080_0000 + (32'(k) << 12) + 32'h20;
      wait_start("pair_d", n, va, r);
      chk("pair_first_data", va, d_vaddr);
      finish(1, 20'h0D000 + 20'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      wait_start("pair_i", n, va, r);
      chk("pair_second_inst", va, i_vaddr);
      finish(1, 20'h0A000 + 20'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pair_d_paddr", d_paddr, {20'h0D000 + 20'(k), 12'h020});
      chk("pair_i_paddr", i_paddr, {20'h0A000 + 20'(k), 12'h010});
    end
    cyc();
    chk("pair_start_count", 32'(start_cnt - base), 32'd8);
    i_en = 1'b0; d_en = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
